// File: rtl/io_port_pkg.sv
// io_port shared definitions: port map,
// STATUS bit layout and access FSM states.
package io_port_pkg;

  localparam logic [7:0] PORT_DATA   = 8'h00;
  localparam logic [7:0] PORT_STATUS = 8'h01;

  localparam int STAT_RXNE   = 0;
  localparam int STAT_TXFULL = 1;
  localparam int STAT_RXOVR  = 2;
  localparam int STAT_TXDROP = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACT  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: byte FIFO, power-of-two depth.
// Push while full is accepted when a pop occurs in the same cycle.
module io_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = reset & pop & ~empty;
  assign do_push = reset & push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  // next pointers and occupancy
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/io_port.sv
// io_port: CPU-mapped byte port with TX/RX FIFOs,
// DATA/STATUS registers and sticky drop/overrun flags.
module io_port
  import io_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic       mem_io,
  input  logic       mem_clk,
  input  logic       c_ri,
  input  logic       c_ro,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  state_e     state_q, state_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_drop_q, tx_drop_d;

  logic       act, wr, rd;
  logic       sel_data, sel_stat;
  logic [7:0] status;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_dout;

  assign act      = reset & (state_q == S_ACT);
  assign wr       = act & c_ri & ~c_ro;
  assign rd       = act & c_ro & ~c_ri;
  assign sel_data = (addr == PORT_DATA);
  assign sel_stat = (addr == PORT_STATUS);

  assign tx_valid = reset & ~tx_empty;
  assign tx_data  = tx_valid ? tx_dout : 8'h00;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr & sel_data & (~tx_full | tx_pop);

  assign rx_ready = reset & ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd & sel_data & ~rx_empty;

  assign bus_oe   = mem_io & c_ro;
  assign bus_out  = (bus_oe & reset) ? rd_data_q : 8'h00;

  // access FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (mem_io && mem_clk) state_d = S_ACT;
      S_ACT:   state_d = S_HOLD;
      S_HOLD:  if (!mem_clk || !mem_io) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // read capture and sticky flags; a new event beats a W1C clear
  always_comb begin
    status = 8'h00;
    status[STAT_RXNE]   = ~rx_empty;
    status[STAT_TXFULL] = tx_full;
    status[STAT_RXOVR]  = rx_ovr_q;
    status[STAT_TXDROP] = tx_drop_q;

    rd_data_d = rd_data_q;
    if (rd) begin
      if (sel_data)
        rd_data_d = rx_empty ? 8'h00 : rx_dout;
      else if (sel_stat)
        rd_data_d = status;
      else
        rd_data_d = 8'h00;
    end

    rx_ovr_d  = rx_ovr_q;
    tx_drop_d = tx_drop_q;
    if (wr && sel_stat) begin
      if (bus_in[STAT_RXOVR])  rx_ovr_d  = 1'b0;
      if (bus_in[STAT_TXDROP]) tx_drop_d = 1'b0;
    end
    if (reset && rx_valid && rx_full)
      rx_ovr_d = 1'b1;
    if (wr && sel_data && tx_full && !tx_pop)
      tx_drop_d = 1'b1;
  end

  // state, read data and flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_data_q <= 8'h00;
      rx_ovr_q  <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_drop_q <= tx_drop_d;
    end
  end

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus_in),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

endmodule

// File: tb/tb_io_port.sv
// tb_io_port: table vectors, directed corner cases
// and a random run against a queue-based model.
module tb_io_port;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr, bus_in, bus_out;
  logic       mem_io, mem_clk, c_ri, c_ro, bus_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_port #(.FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_io   (mem_io),
    .mem_clk  (mem_clk),
    .c_ri     (c_ri),
    .c_ro     (c_ro),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  typedef struct {
    logic [7:0] a;
    logic       ri;
    logic       ro;
    logic [7:0] d;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    mem_io = 0; mem_clk = 0; c_ri = 0; c_ro = 0;
    addr = 8'h00; bus_in = 8'h00;
  endtask

  task automatic do_reset;
    idle_bus;
    tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    reset = 0;
    cyc; cyc;
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_rxr", rx_ready, 0);
    reset = 1;
    cyc;
  endtask

  task automatic access(input logic [7:0] a, input logic ri,
                        input logic ro, input logic [7:0] d,
                        output logic [7:0] q);
    addr = a; bus_in = d; c_ri = ri; c_ro = ro;
    mem_io = 1; mem_clk = 1;
    cyc;
    cyc;
    q = bus_out;
    idle_bus;
    cyc;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    access(a, 1'b1, 1'b0, d, q);
  endtask

  task automatic rd(input string nm, input logic [7:0] a,
                    input logic [7:0] exp);
    logic [7:0] q;
    access(a, 1'b0, 1'b1, 8'h00, q);
    chk(nm, q, exp);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1; rx_data = d;
    cyc;
    rx_valid = 0;
  endtask

  task automatic random_test(input int n);
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       ovr, drop, nov, ndr;
    logic       op, w, r, popt;
    logic [7:0] rdd, stat;
    int         ph, s, txn, rxn;
    do_reset;
    ovr = 0; drop = 0; rdd = 8'h00; ph = 0;
    for (int k = 0; k < n; k++) begin
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      op = (ph == 1);
      if (ph == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          s = $urandom_range(0, 4);
          addr = (s < 2) ? 8'h00 : (s < 4) ? 8'h01 : 8'h5C;
          c_ri = 1'($urandom_range(0, 1));
          c_ro = 1'($urandom_range(0, 1));
          bus_in = 8'($urandom);
          mem_io = 1; mem_clk = 1;
          ph = 1;
        end else begin
          mem_io = 1'($urandom_range(0, 1));
          mem_clk = 0; c_ri = 0;
          c_ro = 1'($urandom_range(0, 1));
        end
      end else if (ph == 1) begin
        ph = 2;
      end else begin
        idle_bus;
        ph = 0;
      end
      #2;
      txn = txq.size();
      rxn = rxq.size();
      chk("rnd_txv", tx_valid, (txn != 0));
      chk("rnd_txd", tx_data, (txn != 0) ? txq[0] : 8'h00);
      chk("rnd_rxr", rx_ready, (rxn < D));
      chk("rnd_oe", bus_oe, mem_io & c_ro);
      chk("rnd_bus", bus_out, (mem_io & c_ro) ? rdd : 8'h00);
      popt = (txn != 0) && tx_ready;
      w = op && c_ri && !c_ro;
      r = op && c_ro && !c_ri;
      stat = {4'b0, drop, ovr, (txn == D), (rxn != 0)};
      nov = ovr; ndr = drop;
      if (w && addr == 8'h01) begin
        if (bus_in[2]) nov = 0;
        if (bus_in[3]) ndr = 0;
      end
      if (r) begin
        if (addr == 8'h00) begin
          rdd = (rxn != 0) ? rxq[0] : 8'h00;
          if (rxn != 0) void'(rxq.pop_front());
        end else if (addr == 8'h01) begin
          rdd = stat;
        end else begin
          rdd = 8'h00;
        end
      end
      if (rx_valid) begin
        if (rxn < D) rxq.push_back(rx_data);
        else nov = 1;
      end
      if (popt) void'(txq.pop_front());
      if (w && addr == 8'h00) begin
        if (txn < D || popt) txq.push_back(bus_in);
        else ndr = 1;
      end
      ovr = nov; drop = ndr;
      @(posedge clk);
      #1;
    end
    idle_bus;
    tx_ready = 0; rx_valid = 0;
    cyc; cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] q;

    tbl[0]  = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{8'h00, 1'b1, 1'b0, 8'hA1, 1'b0, 8'h00};
    tbl[2]  = '{8'h02, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00};
    tbl[3]  = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{8'h00, 1'b1, 1'b0, 8'hA2, 1'b0, 8'h00};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 8'hA3, 1'b0, 8'h00};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 8'hA4, 1'b0, 8'h00};
    tbl[7]  = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02};
    tbl[8]  = '{8'h02, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[9]  = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02};
    tbl[10] = '{8'h00, 1'b1, 1'b1, 8'h55, 1'b1, 8'h02};
    tbl[11] = '{8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[12] = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0A};
    tbl[13] = '{8'h01, 1'b1, 1'b0, 8'h04, 1'b0, 8'h00};
    tbl[14] = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0A};
    tbl[15] = '{8'h01, 1'b1, 1'b0, 8'h08, 1'b0, 8'h00};
    tbl[16] = '{8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02};
    tbl[17] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};

    idle_bus;
    tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    reset = 0;
    mem_io = 1; c_ro = 1;
    cyc; cyc;
    chk("rst_oe", bus_oe, 1);
    chk("rst_bus", bus_out, 8'h00);
    do_reset;

    // table vectors
    for (int i = 0; i < 18; i++) begin
      access(tbl[i].a, tbl[i].ri, tbl[i].ro, tbl[i].d, q);
      if (tbl[i].chk) chk($sformatf("tbl%0d", i), q, tbl[i].exp);
    end
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl_drain%0d", i), tx_data, 8'hA1 + 8'(i));
      cyc;
    end
    chk("tbl_empty", tx_valid, 0);
    tx_ready = 0;

    // single TX write and handshake
    do_reset;
    addr = 8'h00; bus_in = 8'h5A; c_ri = 1;
    mem_io = 1; mem_clk = 1;
    cyc;
    chk("s1_txv_act", tx_valid, 0);
    cyc;
    chk("s1_txv", tx_valid, 1);
    chk("s1_txd", tx_data, 8'h5A);
    idle_bus;
    cyc;
    tx_ready = 1;
    cyc;
    tx_ready = 0;
    chk("s1_txv_pop", tx_valid, 0);
    chk("s1_txd_pop", tx_data, 8'h00);

    // RX push then reads
    do_reset;
    rx_push(8'h11);
    rx_push(8'h22);
    rd("s2_stat", 8'h01, 8'h01);
    rd("s2_d0", 8'h00, 8'h11);
    rd("s2_d1", 8'h00, 8'h22);
    rd("s2_d2", 8'h00, 8'h00);
    rd("s2_stat2", 8'h01, 8'h00);

    // TX overflow, drain, clear drop
    do_reset;
    for (int i = 1; i <= 5; i++) wr(8'h00, 8'(i));
    rd("s3_stat", 8'h01, 8'h0A);
    tx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("s3_v%0d", i), tx_valid, 1);
      chk($sformatf("s3_d%0d", i), tx_data, 8'(i));
      cyc;
    end
    tx_ready = 0;
    chk("s3_empty", tx_valid, 0);
    wr(8'h01, 8'h08);
    rd("s3_stat2", 8'h01, 8'h00);

    // RX overrun
    do_reset;
    rx_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h31 + 8'(i);
      chk($sformatf("s4_rdy%0d", i), rx_ready, (i < 4));
      cyc;
    end
    rx_valid = 0;
    chk("s4_rdy_full", rx_ready, 0);
    rd("s4_stat", 8'h01, 8'h05);
    for (int i = 0; i < 4; i++)
      rd($sformatf("s4_d%0d", i), 8'h00, 8'h31 + 8'(i));

    // both strobes, then long mem_clk
    do_reset;
    rx_push(8'h99);
    access(8'h00, 1'b1, 1'b1, 8'h77, q);
    access(8'h01, 1'b1, 1'b1, 8'h0C, q);
    chk("s5_txv", tx_valid, 0);
    rd("s5_stat", 8'h01, 8'h01);
    addr = 8'h00; bus_in = 8'h66; c_ri = 1;
    mem_io = 1; mem_clk = 1;
    repeat (5) cyc;
    idle_bus;
    cyc;
    chk("s5_txd", tx_data, 8'h66);
    tx_ready = 1;
    cnt = 0;
    repeat (6) begin
      if (tx_valid) cnt++;
      cyc;
    end
    tx_ready = 0;
    chk("s5_pushes", 8'(cnt), 8'd1);
    rd("s5_rx", 8'h00, 8'h99);

    // reset during HOLD and during ACT
    do_reset;
    rx_push(8'h44);
    wr(8'h00, 8'h10);
    wr(8'h00, 8'h11);
    addr = 8'h00; bus_in = 8'h20; c_ri = 1;
    mem_io = 1; mem_clk = 1;
    cyc; cyc;
    reset = 0;
    cyc;
    chk("s6_txv", tx_valid, 0);
    chk("s6_txd", tx_data, 8'h00);
    chk("s6_rxr", rx_ready, 0);
    reset = 1;
    idle_bus;
    cyc; cyc;
    rd("s6_stat", 8'h01, 8'h00);
    chk("s6_txv2", tx_valid, 0);
    addr = 8'h00; bus_in = 8'h33; c_ri = 1;
    mem_io = 1; mem_clk = 1;
    cyc;
    reset = 0;
    cyc;
    reset = 1;
    idle_bus;
    cyc; cyc;
    chk("s6_act_txv", tx_valid, 0);
    rd("s6_act_stat", 8'h01, 8'h00);

    random_test(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
